ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle integer multiply/divide unit that sits beside the single-cycle ALU in the EX stage. It implements SPARC UMUL/SMUL/UDIV/SDIV, each with an optional cc variant. It uses an iterative radix-2 datapath: shift-add for multiply, restoring division for divide. It holds the pipeline through `stall_ex` while iterating, then delivers the result, the Y word and the condition codes with a one-cycle `done` pulse.

---
 rtl/ex_pkg.sv | 16 +
 rtl/ex_muldiv_core.sv | 60 ++++++
 rtl/ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multi-cycle multiply/divide unit:
// opcode encoding and FSM state type.
package ex_pkg;

    localparam logic [1:0] OP_UMUL = 2'b00;
    localparam logic [1:0] OP_SMUL = 2'b01;
    localparam logic [1:0] OP_UDIV = 2'b10;
    localparam logic [1:0] OP_SDIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/ex_muldiv_core.sv
// Radix-2 iterative datapath on unsigned magnitudes: shift-add multiply and
// restoring divide sharing one {hi, lo} accumulator.
module ex_muldiv_core
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             R,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic             div_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rem_ext = {hi_q, lo_q[WIDTH-1]};
        ge      = (rem_ext >= {1'b0, b_q});
        // When ge holds the true remainder is below b_q, so the low bits suffice.
        diff    = rem_ext[WIDTH-1:0] - b_q;
        if (div_q) begin
            nxt_hi = ge ? diff : rem_ext[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= is_div ? hi : '0;
            lo_q  <= a;
            b_q   <= b;
            div_q <= is_div;
        end else if (step) begin
            hi_q  <= nxt_hi;
            lo_q  <= nxt_lo;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle UMUL/SMUL/UDIV/SDIV unit: FSM, sign handling, divide overflow
// saturation and condition-code generation around ex_muldiv_core.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             R,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cc,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Y_in,
    output logic             busy,
    output logic             stall_ex,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] Y_out,
    output logic             we_y,
    output logic             we_psr,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C,
    output logic             dz
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q;
    logic             cc_q, neg_q, ovf_q;

    logic               in_div, in_sgn, a_neg, b_neg, d_neg, b_zero, in_neg, in_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, core_a;
    logic [2*WIDTH-1:0] dvd, dvd_mag;

    always_comb begin
        in_div  = (op == OP_UDIV) || (op == OP_SDIV);
        in_sgn  = (op == OP_SMUL) || (op == OP_SDIV);
        a_neg   = in_sgn & A[WIDTH-1];
        b_neg   = in_sgn & B[WIDTH-1];
        dvd     = {Y_in, A};
        d_neg   = in_sgn & Y_in[WIDTH-1];
        a_mag   = a_neg ? -A : A;
        b_mag   = b_neg ? -B : B;
        dvd_mag = d_neg ? -dvd : dvd;
        b_zero  = (B == '0);
        in_neg  = in_div ? (d_neg ^ b_neg) : (a_neg ^ b_neg);
        // A high word not below the divisor means the quotient cannot fit.
        in_ovf  = in_div & (dvd_mag[2*WIDTH-1:WIDTH] >= b_mag);
        core_a  = in_div ? dvd_mag[WIDTH-1:0] : a_mag;
    end

    logic accept, core_load, core_step, fin_run, fin_dz;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        fin_run   = 1'b0;
        fin_dz    = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (!flush && start) begin
                    accept    = 1'b1;
                    core_load = 1'b1;
                    if (in_div && b_zero) begin
                        state_d = ST_FIN;
                        fin_dz  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_FIN;
                        fin_run = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    ex_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .R      (R),
        .load   (core_load),
        .step   (core_step),
        .is_div (in_div),
        .a      (core_a),
        .b      (b_mag),
        .hi     (dvd_mag[2*WIDTH-1:WIDTH]),
        .nxt_hi (nxt_hi),
        .nxt_lo (nxt_lo)
    );

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, fin_result, fin_y;
    logic               div_ovf, fin_v, fin_dzf;

    always_comb begin
        prod    = {nxt_hi, nxt_lo};
        prod_s  = neg_q ? -prod : prod;
        quo_s   = neg_q ? -nxt_lo : nxt_lo;
        // Signed range: magnitude up to 2^(W-1) when negative, below it when positive.
        div_ovf = ovf_q | ((op_q == OP_SDIV) & (neg_q ? (nxt_lo > SMIN) : (nxt_lo >= SMIN)));
        fin_result = '1;
        fin_y      = '0;
        fin_v      = 1'b0;
        fin_dzf    = 1'b0;
        if (fin_dz) begin
            fin_dzf = 1'b1;
        end else if (op_q == OP_UDIV || op_q == OP_SDIV) begin
            fin_v = div_ovf;
            if (!div_ovf) begin
                fin_result = quo_s;
            end else if (op_q == OP_SDIV) begin
                fin_result = neg_q ? SMIN : SMAX;
            end
        end else begin
            fin_result = prod_s[WIDTH-1:0];
            fin_y      = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_UMUL;
            cc_q    <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= op;
                cc_q  <= cc;
                neg_q <= in_neg;
                ovf_q <= in_ovf;
            end
        end
    end

    logic [WIDTH-1:0] result_q, y_q;
    logic             z_q, n_q, v_q, dz_q;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            result_q <= '0;
            y_q      <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            dz_q     <= 1'b0;
        end else if (fin_run || fin_dz) begin
            result_q <= fin_result;
            y_q      <= fin_y;
            z_q      <= (fin_result == '0);
            n_q      <= fin_result[WIDTH-1];
            v_q      <= fin_v;
            dz_q     <= fin_dzf;
        end
    end

    always_comb begin
        busy     = (state_q == ST_RUN);
        stall_ex = busy;
        // A flush arriving in the result cycle cancels the pulse.
        done     = (state_q == ST_FIN) & ~flush;
        we_y     = done & ((op_q == OP_UMUL) || (op_q == OP_SMUL));
        we_psr   = done & cc_q;
        result   = result_q;
        Y_out    = y_q;
        Z        = z_q;
        N        = n_q;
        V        = v_q;
        C        = 1'b0;
        dz       = dz_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (WIDTH=32): directed cases, random
// operations against an arithmetic reference model, and protocol scenarios.
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         R, start, cc, flush;
    logic [1:0]   op;
    logic [W-1:0] A, B, Y_in;
    logic         busy, stall_ex, done, we_y, we_psr, Z, N, V, C, dz;
    logic [W-1:0] result, Y_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] last_result, last_y;
    logic         last_v, last_n, last_z;

    ex_muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .R        (R),
        .start    (start),
        .op       (op),
        .cc       (cc),
        .flush    (flush),
        .A        (A),
        .B        (B),
        .Y_in     (Y_in),
        .busy     (busy),
        .stall_ex (stall_ex),
        .done     (done),
        .result   (result),
        .Y_out    (Y_out),
        .we_y     (we_y),
        .we_psr   (we_psr),
        .Z        (Z),
        .N        (N),
        .V        (V),
        .C        (C),
        .dz       (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact 64-bit arithmetic, then saturate whatever does not fit.
    function automatic void model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic [31:0] yo, output logic v, output logic dzo);
        longint      sa, sb;
        logic [63:0] p, dvd, bb, mag_d, mag_b, q, rq;
        logic        neg;
        r = 32'h0; yo = 32'h0; v = 1'b0; dzo = 1'b0;
        case (m_op)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                r = p[31:0]; yo = p[63:32];
            end
            2'b01: begin
                sa = $signed(a); sb = $signed(b);
                p = sa * sb;
                r = p[31:0]; yo = p[63:32];
            end
            2'b10: begin
                if (b == 0) begin
                    r = 32'hFFFF_FFFF; dzo = 1'b1;
                end else begin
                    q = {y, a} / {32'h0, b};
                    v = (q > 64'hFFFF_FFFF);
                    r = v ? 32'hFFFF_FFFF : q[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    r = 32'hFFFF_FFFF; dzo = 1'b1;
                end else begin
                    dvd   = {y, a};
                    bb    = {{32{b[31]}}, b};
                    mag_d = dvd[63] ? -dvd : dvd;
                    mag_b = bb[63] ? -bb : bb;
                    neg   = dvd[63] ^ bb[63];
                    q     = mag_d / mag_b;
                    v     = neg ? (q > 64'h8000_0000) : (q > 64'h7FFF_FFFF);
                    rq    = neg ? -q : q;
                    r     = v ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : rq[31:0];
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] t_op, input logic t_cc, input logic [31:0] ta,
                          input logic [31:0] tb_, input logic [31:0] ty, input string tag);
        logic [31:0] er, ey;
        logic        ev, edz, busy_seen, stall_bad;
        int          lat, exp_lat;
        model(t_op, ta, tb_, ty, er, ey, ev, edz);
        op = t_op; cc = t_cc; A = ta; B = tb_; Y_in = ty; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 1; busy_seen = 1'b0; stall_bad = 1'b0;
        while (!done && lat < 100) begin
            if (busy) busy_seen = 1'b1;
            if (stall_ex !== busy) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = edz ? 1 : W + 1;
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        n_checks++;
        if (busy_seen !== !edz || stall_bad !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: seen %b stall_bad %b at_done %b expected seen %b", tag,
                     busy_seen, stall_bad, busy, !edz);
        end
        n_checks++;
        if (result !== er || Y_out !== ey) begin
            n_fail++;
            $display("FAIL %s data: got %h:%h expected %h:%h", tag, Y_out, result, ey, er);
        end
        n_checks++;
        if ({Z, N, V, C, dz} !== {er == 0, er[31], ev, 1'b0, edz}) begin
            n_fail++;
            $display("FAIL %s flags ZNVC/dz: got %b expected %b", tag, {Z, N, V, C, dz},
                     {er == 0, er[31], ev, 1'b0, edz});
        end
        n_checks++;
        if ({we_y, we_psr} !== {!t_op[1], t_cc}) begin
            n_fail++;
            $display("FAIL %s write enables: got %b expected %b", tag, {we_y, we_psr},
                     {!t_op[1], t_cc});
        end
        last_result = er; last_y = ey; last_v = ev; last_n = er[31]; last_z = (er == 0);
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || we_y !== 1'b0 || we_psr !== 1'b0) begin
            n_fail++; $display("FAIL %s pulse width: done %b one cycle later", tag, done);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({result, Y_out, busy, stall_ex, done, we_y, we_psr, Z, N, V, C, dz} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: result %h Y %h busy %b done %b flags %b", result, Y_out,
                     busy, done, {Z, N, V, C, dz});
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "umul_max");
        n_checks++;
        if (last_result !== 32'h1 || last_y !== 32'hFFFF_FFFE || last_z || last_n) begin
            n_fail++; $display("FAIL umul_max const: got %h:%h", last_y, last_result);
        end
        run_op(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'h0, "smul_neg");
        n_checks++;
        if (last_result !== 32'hFFFF_FFEB || last_y !== 32'hFFFF_FFFF || !last_n) begin
            n_fail++; $display("FAIL smul_neg const: got %h:%h", last_y, last_result);
        end
        run_op(2'b10, 1'b0, 32'd100, 32'd7, 32'h0, "udiv_small");
        n_checks++;
        if (last_result !== 32'd14 || last_v) begin
            n_fail++; $display("FAIL udiv_small const: got %h v %b", last_result, last_v);
        end
        run_op(2'b10, 1'b1, 32'h0, 32'd1, 32'h1, "udiv_ovf");
        n_checks++;
        if (last_result !== 32'hFFFF_FFFF || !last_v) begin
            n_fail++; $display("FAIL udiv_ovf const: got %h v %b", last_result, last_v);
        end
        run_op(2'b11, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF, "sdiv_neg");
        n_checks++;
        if (last_result !== 32'hFFFF_FFF2 || !last_n) begin
            n_fail++; $display("FAIL sdiv_neg const: got %h", last_result);
        end
        run_op(2'b11, 1'b1, 32'h8000_0000, 32'd1, 32'h0, "sdiv_ovf");
        n_checks++;
        if (last_result !== 32'h7FFF_FFFF || !last_v) begin
            n_fail++; $display("FAIL sdiv_ovf const: got %h v %b", last_result, last_v);
        end
        run_op(2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "sdiv_min_neg");
        run_op(2'b10, 1'b1, 32'd55, 32'h0, 32'h0, "udiv_zero");
        run_op(2'b11, 1'b0, 32'd55, 32'h0, 32'h0, "sdiv_zero");
    endtask

    task automatic test_random();
        logic [1:0]  r_op;
        logic [31:0] ra, rb, ry;
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            ra   = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1, 2, 3: rb = $urandom_range(1, 1000);
                default: rb = $urandom;
            endcase
            ry = $urandom;
            if (r_op == 2'b10 && rb != 0 && $urandom_range(0, 3) != 0) ry = ry % rb;
            if (r_op == 2'b11 && $urandom_range(0, 3) != 0) ry = ra[31] ? 32'hFFFF_FFFF : 32'h0;
            run_op(r_op, 1'($urandom_range(0, 1)), ra, rb, ry, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_flush();
        bit saw_done = 0;
        run_op(2'b01, 1'b0, 32'hFFFF_FFF0, 32'd3, 32'h0, "pre_flush");
        op = 2'b00; cc = 1'b1; A = 32'h1234_5678; B = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL flush idle: busy %b done %b expected 0 0", busy, done);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        n_checks++;
        if (saw_done || result !== last_result || Y_out !== last_y) begin
            n_fail++;
            $display("FAIL flush retain: activity %b got %h:%h expected %h:%h", saw_done, Y_out,
                     result, last_y, last_result);
        end
    endtask

    task automatic test_start_ignored();
        int  lat = 1;
        bit  extra = 0;
        op = 2'b10; cc = 1'b0; A = 32'd100; B = 32'd7; Y_in = 32'h0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 op = 2'b01; A = 32'hFFFF_FFFF; B = 32'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== W + 1 || result !== 32'd14) begin
            n_fail++;
            $display("FAIL ignore_start: latency %0d result %h expected %0d 0000000e", lat, result,
                     W + 1);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra = 1;
        end
        n_checks++;
        if (extra) begin
            n_fail++; $display("FAIL ignore_start extra op: activity %b expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        op = 2'b00; cc = 1'b1; A = 32'hDEAD_BEEF; B = 32'h0000_0101; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #2 R = 1'b1;
        #1;
        n_checks++;
        if ({result, Y_out, busy, stall_ex, done, we_y, we_psr, Z, N, V, C, dz} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: result %h Y %h busy %b done %b expected all 0", result, Y_out,
                     busy, done);
        end
        @(posedge clk); #1 R = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset idle: busy %b done %b expected 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er, ey;
        logic        ev, edz;
        int          t1 = 0, t2 = 0, guard = 0;
        op = 2'b00; cc = 1'b0; A = 32'd123456; B = 32'd654321; Y_in = 32'h0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        t1 = cyc;
        model(2'b00, 32'd123456, 32'd654321, 32'h0, er, ey, ev, edz);
        n_checks++;
        if (!done || result !== er || Y_out !== ey) begin
            n_fail++; $display("FAIL b2b first: done %b got %h:%h expected %h:%h", done, Y_out,
                               result, ey, er);
        end
        op = 2'b11; cc = 1'b1; A = 32'hFFFF_F000; B = 32'd9; Y_in = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b restart: busy %b done %b expected 1 0", busy, done);
        end
        guard = 0;
        while (!done && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        t2 = cyc;
        model(2'b11, 32'hFFFF_F000, 32'd9, 32'hFFFF_FFFF, er, ey, ev, edz);
        n_checks++;
        if (!done || t2 - t1 !== W + 1 || result !== er || we_psr !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b second: done %b gap %0d result %h expected gap %0d result %h", done,
                     t2 - t1, result, W + 1, er);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        R = 1'b1; start = 1'b0; flush = 1'b0; cc = 1'b0; op = 2'b00;
        A = '0; B = '0; Y_in = '0;
        repeat (3) @(posedge clk);
        #1 test_reset();
        R = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
